// File: rtl/mcmm_pkg.sv
// Shared types, defaults and helpers for the multi-channel min/max extractor.
package mcmm_pkg;

    localparam int unsigned MCMM_DATA_WIDTH   = 8;
    localparam int unsigned MCMM_NUM_CH       = 3;
    localparam int unsigned MCMM_FRAME_PIXELS = 76800;

    // Frame-control state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mcmm_state_e;

    // LSB position of channel ch inside a packed beat.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/ch_min_max_update.sv
// Running min/max tracker for a single channel, with the beat folded in combinationally.
module ch_min_max_update #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  upd,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] min_nxt_c,
    output logic [DATA_WIDTH-1:0] max_nxt_c,
    output logic [DATA_WIDTH-1:0] range_c
);

    logic [DATA_WIDTH-1:0] run_min_q;
    logic [DATA_WIDTH-1:0] run_max_q;

    // Running values including the current sample; range taken over them.
    always_comb begin
        min_nxt_c = (sample < run_min_q) ? sample : run_min_q;
        max_nxt_c = (sample > run_max_q) ? sample : run_max_q;
        range_c   = max_nxt_c - min_nxt_c;
    end

    // Accumulator registers: seed at frame start, fold on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_min_q <= '0;
            run_max_q <= '0;
        end else if (init) begin
            run_min_q <= '1;
            run_max_q <= '0;
        end else if (upd) begin
            run_min_q <= min_nxt_c;
            run_max_q <= max_nxt_c;
        end
    end

endmodule

// File: rtl/multi_ch_min_max.sv
// Streaming per-channel min/max/range extractor with frame-length check.
module multi_ch_min_max
    import mcmm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = MCMM_DATA_WIDTH,
    parameter int unsigned NUM_CH       = MCMM_NUM_CH,
    parameter int unsigned FRAME_PIXELS = MCMM_FRAME_PIXELS,
    parameter int unsigned CNT_WIDTH    = $clog2(FRAME_PIXELS + 1)
) (
    input  logic                         clk_i_mcmm,
    input  logic                         rst_i_mcmm,
    input  logic                         start_i_mcmm,
    input  logic                         valid_i_mcmm,
    output logic                         ready_o_mcmm,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i_mcmm,
    input  logic                         last_i_mcmm,
    output logic [NUM_CH*DATA_WIDTH-1:0] min_o_mcmm,
    output logic [NUM_CH*DATA_WIDTH-1:0] max_o_mcmm,
    output logic [NUM_CH*DATA_WIDTH-1:0] range_o_mcmm,
    output logic [CNT_WIDTH-1:0]         count_o_mcmm,
    output logic                         busy_o_mcmm,
    output logic                         done_o_mcmm,
    output logic                         err_len_o_mcmm
);

    localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] FRAME_LEN = CNT_WIDTH'(FRAME_PIXELS);

    mcmm_state_e state_q;
    mcmm_state_e state_d;
    logic        init_c;
    logic        accept_c;
    logic        last_acc_c;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_nxt_c;

    logic [BUS_W-1:0] min_nxt_bus;
    logic [BUS_W-1:0] max_nxt_bus;
    logic [BUS_W-1:0] range_bus;

    // One tracker per channel slice.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_min_max_update #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk       (clk_i_mcmm),
            .rst       (rst_i_mcmm),
            .init      (init_c),
            .upd       (accept_c),
            .sample    (data_i_mcmm[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .min_nxt_c (min_nxt_bus[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .max_nxt_c (max_nxt_bus[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .range_c   (range_bus[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    // Saturating beat count including the current beat.
    always_comb begin
        cnt_nxt_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d    = state_q;
        init_c     = 1'b0;
        accept_c   = 1'b0;
        last_acc_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i_mcmm) begin
                    state_d = ST_RUN;
                    init_c  = 1'b1;
                end
            end
            ST_RUN: begin
                if (valid_i_mcmm) begin
                    accept_c = 1'b1;
                    if (last_i_mcmm) begin
                        last_acc_c = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start_i_mcmm) begin
                    state_d = ST_RUN;
                    init_c  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, status flags and result snapshot.
    always_ff @(posedge clk_i_mcmm) begin
        if (rst_i_mcmm) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ready_o_mcmm   <= 1'b0;
            busy_o_mcmm    <= 1'b0;
            done_o_mcmm    <= 1'b0;
            err_len_o_mcmm <= 1'b0;
            min_o_mcmm     <= '0;
            max_o_mcmm     <= '0;
            range_o_mcmm   <= '0;
            count_o_mcmm   <= '0;
        end else begin
            state_q      <= state_d;
            ready_o_mcmm <= (state_d == ST_RUN);
            busy_o_mcmm  <= (state_d == ST_RUN);
            done_o_mcmm  <= (state_d == ST_DONE);
            if (init_c) begin
                cnt_q <= '0;
            end else if (accept_c) begin
                cnt_q <= cnt_nxt_c;
            end
            // Snapshot on the last beat so results are valid alongside done.
            if (last_acc_c) begin
                min_o_mcmm     <= min_nxt_bus;
                max_o_mcmm     <= max_nxt_bus;
                range_o_mcmm   <= range_bus;
                count_o_mcmm   <= cnt_nxt_c;
                err_len_o_mcmm <= (cnt_nxt_c != FRAME_LEN);
            end
        end
    end

endmodule

// File: tb/tb_multi_ch_min_max.sv
// Scoreboard bench for multi_ch_min_max (3-channel and 1-channel instances).
module tb_multi_ch_min_max;

    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 3;
    localparam int unsigned FP  = 16;
    localparam int unsigned CW  = 5;
    localparam int unsigned BW  = NCH * DW;

    typedef struct packed {
        logic [BW-1:0] mn;
        logic [BW-1:0] mx;
        logic [BW-1:0] rg;
        logic [CW-1:0] cnt;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [BW-1:0] data  = '0;
    logic          last  = 1'b0;
    logic          ready, busy, done, err_len;
    logic [BW-1:0] min_o, max_o, range_o;
    logic [CW-1:0] count_o;

    logic          start1 = 1'b0;
    logic          valid1 = 1'b0;
    logic [DW-1:0] data1  = '0;
    logic          last1  = 1'b0;
    logic          ready1, busy1, done1, err1;
    logic [DW-1:0] min1, max1, range1;
    logic [0:0]    count1;

    multi_ch_min_max #(.DATA_WIDTH(DW), .NUM_CH(NCH), .FRAME_PIXELS(FP)) u_dut (
        .clk_i_mcmm     (clk),
        .rst_i_mcmm     (rst),
        .start_i_mcmm   (start),
        .valid_i_mcmm   (valid),
        .ready_o_mcmm   (ready),
        .data_i_mcmm    (data),
        .last_i_mcmm    (last),
        .min_o_mcmm     (min_o),
        .max_o_mcmm     (max_o),
        .range_o_mcmm   (range_o),
        .count_o_mcmm   (count_o),
        .busy_o_mcmm    (busy),
        .done_o_mcmm    (done),
        .err_len_o_mcmm (err_len)
    );

    multi_ch_min_max #(.DATA_WIDTH(DW), .NUM_CH(1), .FRAME_PIXELS(1)) u_dut1 (
        .clk_i_mcmm     (clk),
        .rst_i_mcmm     (rst),
        .start_i_mcmm   (start1),
        .valid_i_mcmm   (valid1),
        .ready_o_mcmm   (ready1),
        .data_i_mcmm    (data1),
        .last_i_mcmm    (last1),
        .min_o_mcmm     (min1),
        .max_o_mcmm     (max1),
        .range_o_mcmm   (range1),
        .count_o_mcmm   (count1),
        .busy_o_mcmm    (busy1),
        .done_o_mcmm    (done1),
        .err_len_o_mcmm (err1)
    );

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    int   n_push = 0;
    exp_t sb[$];
    logic exp_done_now = 1'b0;

    logic [DW-1:0] m_min [NCH];
    logic [DW-1:0] m_max [NCH];
    int            m_cnt;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_init();
        for (int c = 0; c < NCH; c++) begin
            m_min[c] = '1;
            m_max[c] = '0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_fold(input logic [BW-1:0] d);
        for (int c = 0; c < NCH; c++) begin
            logic [DW-1:0] s;
            s = d[c*DW +: DW];
            if (s < m_min[c]) m_min[c] = s;
            if (s > m_max[c]) m_max[c] = s;
        end
        m_cnt++;
    endfunction

    function automatic void push_exp();
        exp_t e;
        int   sat;
        for (int c = 0; c < NCH; c++) begin
            e.mn[c*DW +: DW] = m_min[c];
            e.mx[c*DW +: DW] = m_max[c];
            e.rg[c*DW +: DW] = m_max[c] - m_min[c];
        end
        sat   = (m_cnt > 31) ? 31 : m_cnt;
        e.cnt = CW'(sat);
        e.err = (sat != int'(FP));
        sb.push_back(e);
        n_push++;
        model_init();
    endfunction

    function automatic logic [BW-1:0] pat(input int i);
        logic [DW-1:0] c0, c2;
        c0 = DW'(28 + 13 * i);
        c2 = (i % 2 == 1) ? 8'hFF : 8'h00;
        return {c2, 8'd100, c0};
    endfunction

    // Result monitor: pop the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("min", 64'(min_o), 64'(e.mn));
                check("max", 64'(max_o), 64'(e.mx));
                check("range", 64'(range_o), 64'(e.rg));
                check("count", 64'(count_o), 64'(e.cnt));
                check("err_len", 64'(err_len), 64'(e.err));
            end
        end
    end

    // One clock of stimulus, driven on the falling edge.
    task automatic step(input logic s, input logic v, input logic [BW-1:0] d, input logic l,
                        input logic chk_rdy, output logic acc);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(exp_done_now));
        exp_done_now = 1'b0;
        if (chk_rdy) check("ready_run", 64'(ready), 64'd1);
        start = s;
        valid = v;
        data  = d;
        last  = l;
        acc   = v && ready;
        if (acc) begin
            model_fold(d);
            if (l) begin
                push_exp();
                exp_done_now = 1'b1;
            end
        end
    endtask

    task automatic arm();
        logic acc;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic idle();
        logic acc;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    // kind: 0 test pattern, 1 random, 2 constant. mid_start = beat index carrying a start pulse.
    task automatic run_frame(input int n, input int gap_pct, input int kind,
                             input int mid_start, input bit do_last);
        logic          acc;
        logic [BW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = (kind == 0) ? pat(i) : (kind == 1) ? BW'($urandom) : 24'h777777;
            for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++)
                step(1'b0, 1'b0, BW'($urandom), 1'b1, 1'b1, acc);
            acc = 1'b0;
            for (int t = 0; t < 4 && !acc; t++)
                step(1'b0 | (i == mid_start), 1'b1, d, do_last && (i == n - 1), 1'b1, acc);
            if (!acc) check("beat_accept", 64'd0, 64'd1);
        end
    endtask

    task automatic check_pattern_result();
        check("pat_min", 64'(min_o), 64'h00641C);
        check("pat_max", 64'(max_o), 64'hFF64DF);
        check("pat_range", 64'(range_o), 64'hFF00C3);
        check("pat_count", 64'(count_o), 64'd16);
        check("pat_err", 64'(err_len), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err_len), 64'd0);
        check({tag, "_min"}, 64'(min_o), 64'd0);
        check({tag, "_max"}, 64'(max_o), 64'd0);
        check({tag, "_range"}, 64'(range_o), 64'd0);
        check({tag, "_count"}, 64'(count_o), 64'd0);
    endtask

    initial begin
        logic acc;
        model_init();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset");

        // Gap-free reference frame.
        arm();
        run_frame(16, 0, 0, -1, 1'b1);
        idle();
        check_pattern_result();

        // Same frame with random valid gaps.
        arm();
        run_frame(16, 50, 0, -1, 1'b1);
        idle();
        check_pattern_result();

        // Short frame, then back-to-back long frame started in the DONE cycle.
        arm();
        run_frame(10, 0, 1, -1, 1'b1);
        arm();
        run_frame(20, 20, 1, -1, 1'b1);
        idle();
        check("long_err", 64'(err_len), 64'd1);
        check("long_count", 64'(count_o), 64'd20);

        // start mid-frame is ignored.
        arm();
        run_frame(16, 0, 0, 5, 1'b1);
        idle();
        check_pattern_result();

        // All-equal samples give zero range.
        arm();
        run_frame(16, 0, 2, -1, 1'b1);
        idle();
        check("equal_range", 64'(range_o), 64'd0);

        // Count saturation with an overlong frame.
        arm();
        run_frame(40, 0, 1, -1, 1'b1);
        idle();
        check("sat_count", 64'(count_o), 64'd31);

        // Reset mid-frame discards the partial frame.
        arm();
        run_frame(7, 0, 0, -1, 1'b0);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("midrst");
        model_init();
        exp_done_now = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, pat(k), 1'b1, 1'b0, acc);
            check("idle_no_accept", 64'(acc), 64'd0);
        end
        arm();
        run_frame(16, 0, 0, -1, 1'b1);
        idle();
        check_pattern_result();

        // Single-channel, single-beat frame on the second instance.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("g_ready", 64'(ready1), 64'd1);
        valid1 = 1'b1;
        data1  = 8'h5A;
        last1  = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        last1  = 1'b0;
        check("g_done", 64'(done1), 64'd1);
        check("g_min", 64'(min1), 64'h5A);
        check("g_max", 64'(max1), 64'h5A);
        check("g_range", 64'(range1), 64'd0);
        check("g_err", 64'(err1), 64'd0);
        check("g_count", 64'(count1), 64'd1);

        for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("done_total", 64'(n_done), 64'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
